// File: rtl/gate_mon_pkg.sv
// rtl/gate_mon_pkg.sv - shared types and saturation limits for gate_match_monitor
package gate_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HIT  = 2'b10
    } state_t;

    function automatic int sat_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_RUN_W   = 4;
    localparam int DEF_CNT_MAX = sat_max(DEF_CNT_W);
    localparam int DEF_RUN_MAX = sat_max(DEF_RUN_W);

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with synchronous clear that sticks at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != MAX)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/gate_match_monitor.sv
// rtl/gate_match_monitor.sv - edge/run monitor for the gate output; GATE_MON_STICKY_EN makes det sticky
module gate_match_monitor
    import gate_mon_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int RUN_W      = DEF_RUN_W,
    parameter int RUN_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             y_in,
    input  logic             clr,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic [RUN_W-1:0] run_len,
    output logic             det,
    output logic [1:0]       state_o
);

    if ((RUN_THRESH < 1) || (RUN_THRESH > sat_max(RUN_W))) begin : g_bad_thresh
        $error("gate_match_monitor: RUN_THRESH out of range 1..2^RUN_W-1");
    end

    // A sample of 1 reaches the threshold when the pre-increment length is already THRESH-1.
    localparam logic [RUN_W-1:0] THRESH_M1 = RUN_W'(RUN_THRESH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_prev_y;
    logic               r_rise;
    logic               r_det;
    logic               w_det_next;
    logic               w_clear;
    logic               w_sample;
    logic               w_rise;
    logic               w_reach;
    logic [CNT_W-1:0]   w_match_count;
    logic [RUN_W-1:0]   w_run_len;

    assign w_clear  = rst | clr;
    assign w_sample = in_valid & ~w_clear;
    assign w_rise   = w_sample & y_in & ~r_prev_y;
    assign w_reach  = (w_run_len >= THRESH_M1);

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk (clk),
        .clr (w_clear),
        .inc (w_rise),
        .q   (w_match_count)
    );

    sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk (clk),
        .clr (w_clear | (w_sample & ~y_in)),
        .inc (w_sample & y_in),
        .q   (w_run_len)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_sample && y_in) w_state_next = w_reach ? HIT : RUN;
            RUN:  if (w_sample)         w_state_next = y_in ? (w_reach ? HIT : RUN) : IDLE;
            HIT:  if (w_sample && !y_in) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

`ifdef GATE_MON_STICKY_EN
    assign w_det_next = r_det | (w_state_next == HIT);
`else
    assign w_det_next = (w_state_next == HIT);
`endif

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state  <= IDLE;
            r_prev_y <= 1'b0;
            r_rise   <= 1'b0;
            r_det    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rise  <= w_rise;
            r_det   <= w_det_next;
            if (w_sample) begin
                r_prev_y <= y_in;
            end
        end
    end

    assign rise_pulse  = r_rise;
    assign match_count = w_match_count;
    assign run_len     = w_run_len;
    assign det         = r_det;
    assign state_o     = r_state;

endmodule

// File: tb/tb_gate_match_monitor.sv
// tb/tb_gate_match_monitor.sv - scoreboard bench for gate_match_monitor
module tb_gate_match_monitor;

    localparam int CNT_W = 8;
    localparam int RUN_W = 4;
    localparam int TH    = 3;
    localparam int CMAX  = 255;
    localparam int RMAX  = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             y_in = 1'b0;
    logic             clr = 1'b0;
    logic             rise_pulse;
    logic [CNT_W-1:0] match_count;
    logic [RUN_W-1:0] run_len;
    logic             det;
    logic [1:0]       state_o;

    gate_match_monitor #(
        .CNT_W      (CNT_W),
        .RUN_W      (RUN_W),
        .RUN_THRESH (TH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .y_in        (y_in),
        .clr         (clr),
        .rise_pulse  (rise_pulse),
        .match_count (match_count),
        .run_len     (run_len),
        .det         (det),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rise;
        int cnt;
        int run;
        int det;
        int st;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int m_prev = 0, m_cnt = 0, m_run = 0, m_st = 0, m_det = 0, m_rise = 0;
    int rise_seen = 0;
    int det_seen  = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model(input logic r, input logic c, input logic v, input logic y);
        if (r || c) begin
            m_prev = 0; m_cnt = 0; m_run = 0; m_st = 0; m_det = 0; m_rise = 0;
        end else if (v) begin
            m_rise = (y && m_prev == 0) ? 1 : 0;
            if (m_rise == 1 && m_cnt < CMAX) m_cnt++;
            if (y) begin
                if (m_run < RMAX) m_run++;
                if (m_st == 2 || m_run >= TH) m_st = 2;
                else m_st = 1;
            end else begin
                m_run = 0;
                m_st  = 0;
            end
`ifdef GATE_MON_STICKY_EN
            if (m_st == 2) m_det = 1;
`else
            m_det = (m_st == 2) ? 1 : 0;
`endif
            m_prev = y ? 1 : 0;
        end else begin
            m_rise = 0;
        end
    endtask

    task automatic step(input logic r, input logic c, input logic v, input logic y);
        exp_t e;
        @(negedge clk);
        rst = r; clr = c; in_valid = v; y_in = y;
        model(r, c, v, y);
        e = '{rise: m_rise, cnt: m_cnt, run: m_run, det: m_det, st: m_st};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("rise",  rise_pulse, e.rise);
        chk("count", match_count, e.cnt);
        chk("run",   run_len, e.run);
        chk("det",   det, e.det);
        chk("state", state_o, e.st);
        rise_seen += int'(rise_pulse);
        if (det) det_seen = 1;
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_count", match_count, 0);
        chk("rst_state", state_o, 0);

        // basic run reaching the threshold
        rise_seen = 0;
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        chk("t1_rise_s2", rise_pulse, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        chk("t1_det_s4", det, 1);
        step(0, 0, 1, 0);
        chk("t1_state_s5", state_o, 0);
        chk("t1_count", match_count, 1);
        chk("t1_rises", rise_seen, 1);

        // invalid gaps inside a run
        step(0, 1, 0, 0);
        rise_seen = 0;
        step(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        chk("t2_det_v2", det, 0);
        step(0, 0, 1, 1);
        chk("t2_det_v3", det, 1);
        chk("t2_run", run_len, 3);
        chk("t2_rises", rise_seen, 1);

        // match_count saturation
        step(0, 1, 0, 0);
        det_seen = 0;
        for (int i = 0; i < 300; i++) begin
            step(0, 0, 1, 1);
            step(0, 0, 1, 0);
        end
        chk("t3_count_sat", match_count, CMAX);
        chk("t3_no_det", det_seen, 0);

        // run_len saturation
        step(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1);
        chk("t4_run_sat", run_len, RMAX);
        chk("t4_det", det, 1);
        chk("t4_count", match_count, 1);

        // clear wins over a same-cycle sample
        step(0, 1, 1, 1);
        chk("t5_rise", rise_pulse, 0);
        chk("t5_count", match_count, 0);
        chk("t5_run", run_len, 0);
        chk("t5_det", det, 0);
        chk("t5_state", state_o, 0);
        step(0, 0, 1, 1);
        chk("t5_rise_after", rise_pulse, 1);

        // det behaviour after leaving HIT
        step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
        step(0, 0, 1, 0);
`ifdef GATE_MON_STICKY_EN
        chk("t6_det_s4", det, 1);
`else
        chk("t6_det_s4", det, 0);
`endif
        step(0, 0, 1, 0);
        chk("t6_state", state_o, 0);
        step(0, 1, 0, 0);
        chk("t6_det_clr", det, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
